// File: rtl/serial_word_source.sv
// serial_word_source: parallel-to-serial word source, MSB first, with inter-word idle gap and frame markers.
// Optional even-parity trailer bit enabled by defining SERIAL_WORD_SOURCE_PARITY_EN.
module serial_word_source #(
  parameter int WIDTH = 8,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             x_out,
  output logic             x_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);
`ifdef SERIAL_WORD_SOURCE_PARITY_EN
  localparam int L = WIDTH + 1;
`else
  localparam int L = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 1);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;
  state_t           r_state, w_state_nx;
  logic [WIDTH-1:0] r_sh, w_sh_nx;
  logic [CW-1:0]    r_cnt, w_cnt_nx;
  logic [GW-1:0]    r_gap, w_gap_nx;
  logic             w_x, w_xv, w_fs, w_fe, w_next_bit;
`ifdef SERIAL_WORD_SOURCE_PARITY_EN
  logic             r_par, w_par_nx;
  // the bit after the data LSB is the parity captured with the word
  assign w_next_bit = (r_cnt == CW'(WIDTH - 1)) ? r_par : r_sh[WIDTH-2];
`else
  assign w_next_bit = r_sh[WIDTH-2];
`endif
  assign load_ready = (r_state == S_IDLE) && !rst;
  assign busy       = (r_state != S_IDLE);
  always_comb begin
    w_state_nx = r_state;
    w_sh_nx    = r_sh;
    w_cnt_nx   = r_cnt;
    w_gap_nx   = r_gap;
    w_x        = 1'b0;
    w_xv       = 1'b0;
    w_fs       = 1'b0;
    w_fe       = 1'b0;
`ifdef SERIAL_WORD_SOURCE_PARITY_EN
    w_par_nx   = r_par;
`endif
    case (r_state)
      S_IDLE: if (load_valid) begin
        w_state_nx = S_SHIFT;
        w_sh_nx    = load_data;
        w_cnt_nx   = '0;
        w_x        = load_data[WIDTH-1];
        w_xv       = 1'b1;
        w_fs       = 1'b1;
`ifdef SERIAL_WORD_SOURCE_PARITY_EN
        w_par_nx   = ^load_data;
`endif
      end
      S_SHIFT: if (r_cnt == CW'(L - 1)) begin
        w_state_nx = (GAP == 0) ? S_IDLE : S_GAP;
        w_gap_nx   = '0;
      end else begin
        w_sh_nx  = r_sh << 1;
        w_cnt_nx = r_cnt + 1'b1;
        w_x      = w_next_bit;
        w_xv     = 1'b1;
        w_fe     = (r_cnt == CW'(L - 2));
      end
      S_GAP: begin
        w_state_nx = (r_gap == GW'(GAP_LAST)) ? S_IDLE : S_GAP;
        w_gap_nx   = r_gap + 1'b1;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sh        <= '0;
      r_cnt       <= '0;
      r_gap       <= '0;
      x_out       <= 1'b0;
      x_valid     <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
`ifdef SERIAL_WORD_SOURCE_PARITY_EN
      r_par       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nx;
      r_sh        <= w_sh_nx;
      r_cnt       <= w_cnt_nx;
      r_gap       <= w_gap_nx;
      x_out       <= w_x;
      x_valid     <= w_xv;
      frame_start <= w_fs;
      frame_end   <= w_fe;
`ifdef SERIAL_WORD_SOURCE_PARITY_EN
      r_par       <= w_par_nx;
`endif
    end
  end
endmodule

// File: tb/tb_serial_word_source.sv
// tb_serial_word_source: directed and random frames checked against a bit-list model of the serial source.
module tb_serial_word_source;
`ifdef SERIAL_WORD_SOURCE_PARITY_EN
  localparam int L = 9;
`else
  localparam int L = 8;
`endif
  localparam int GAP_P = 2;
  localparam int P0 = L + 1;
  logic clk = 1'b0;
  logic rst = 1'b1, load_valid = 1'b0;
  logic [7:0] load_data = '0;
  logic load_ready, x_out, x_valid, frame_start, frame_end, busy;
  logic rst0 = 1'b1, v0 = 1'b0;
  logic [7:0] d0 = '0;
  logic r0, x0, xv0, fs0, fe0, b0;
  int n_chk = 0, n_fail = 0;
  time t_cap = 0, t_prev = 0;
  always #5 clk = ~clk;
  serial_word_source #(.WIDTH(8), .GAP(GAP_P)) u_dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .x_out(x_out), .x_valid(x_valid),
    .frame_start(frame_start), .frame_end(frame_end), .busy(busy));
  serial_word_source #(.WIDTH(8), .GAP(0)) u_g0 (
    .clk(clk), .rst(rst0), .load_valid(v0), .load_data(d0),
    .load_ready(r0), .x_out(x0), .x_valid(xv0),
    .frame_start(fs0), .frame_end(fe0), .busy(b0));
  function automatic logic exp_bit(input logic [7:0] w, input int i);
    return (i < 8) ? w[7-i] : logic'($countones(w) % 2);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_frame(input logic [7:0] w, input logic [7:0] nxt, input logic keep);
    int n = 0;
    load_valid = 1'b1;
    load_data  = w;
    while (!load_ready && n < 100) begin
      tick();
      n++;
    end
    chk("ready_wait", load_ready, 1);
    tick();
    t_prev = t_cap;
    t_cap  = $time;
    load_valid = keep;
    load_data  = nxt;
    for (int i = 0; i < L; i++) begin
      chk("x_out", x_out, exp_bit(w, i));
      chk("x_valid", x_valid, 1);
      chk("frame_start", frame_start, i == 0);
      chk("frame_end", frame_end, i == L - 1);
      chk("ready_busy", {load_ready, busy}, 2'b01);
      tick();
    end
    for (int g = 0; g < GAP_P; g++) begin
      chk("gap_out", {x_out, x_valid, frame_start, frame_end}, 0);
      chk("gap_ready_busy", {load_ready, busy}, 2'b01);
      tick();
    end
    chk("ready_back", {load_ready, busy}, 2'b10);
  endtask
  initial begin
    #2;
    chk("rst_out", {x_out, x_valid, frame_start, frame_end, busy}, 0);
    chk("rst_ready", load_ready, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("idle_ready", {load_ready, busy}, 2'b10);
    run_frame(8'hB4, 8'h00, 1'b0);
    run_frame(8'hFF, 8'h01, 1'b1);
    run_frame(8'h01, 8'h00, 1'b0);
    chk("b2b_spacing", 32'(t_cap - t_prev), 32'((L + GAP_P + 1) * 10));
    run_frame(8'hC3, 8'h3C, 1'b0);
    run_frame(8'h07, 8'h00, 1'b0);
    run_frame(8'h03, 8'h00, 1'b0);
    load_valid = 1'b1;
    load_data  = 8'hAA;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("pre_rst_bit", x_out, exp_bit(8'hAA, i));
      tick();
    end
    #3 rst = 1'b1;
    #1;
    chk("async_rst", {x_out, x_valid, busy, load_ready}, 0);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_idle", {x_valid, busy, load_ready}, 3'b001);
    end
    run_frame(8'h0F, 8'h00, 1'b0);
    for (int r = 0; r < 6; r++) run_frame(8'($urandom), 8'($urandom), 1'b0);
    d0 = 8'($urandom);
    v0 = 1'b1;
    #2 rst0 = 1'b0;
    tick();
    for (int t = 0; t < 3 * P0; t++) begin
      chk("g0_valid", xv0, (t % P0) != P0 - 1);
      chk("g0_ready", r0, (t % P0) == P0 - 1);
      chk("g0_start", fs0, (t % P0) == 0);
      if ((t % P0) != P0 - 1) chk("g0_bit", x0, exp_bit(d0, t % P0));
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
